// File: rtl/hslp_pkg.sv
// Shared types and constants for the sequential nibble multiplier.
// Phase shifts place each 4x4 partial product at its nibble weight.
package hslp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HH   = 3'd1,
    ST_HL   = 3'd2,
    ST_LH   = 3'd3,
    ST_LL   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int SH_HH = 8;
  localparam int SH_HL = 4;
  localparam int SH_LH = 4;
  localparam int SH_LL = 0;

  localparam int ACC_W = 17;

  localparam logic [1:0] PP_EXACT = 2'd0;
  localparam logic [1:0] PP_AP1   = 2'd1;
  localparam logic [1:0] PP_AP3   = 2'd2;

endpackage

// File: rtl/hslp_pp_slot.sv
// Single shared 4x4 partial-product slot: exact, ap1 or ap3 result picked by mode.
// ap1/ap3 replace the low 2/3 product bits by their OR, so they never undershoot.
module hslp_ap1 (
  input  logic [7:0] i_p,
  output logic [7:0] o_p
);
  assign o_p = {i_p[7:2], {2{|i_p[1:0]}}};
endmodule

module hslp_ap3 (
  input  logic [7:0] i_p,
  output logic [7:0] o_p
);
  assign o_p = {i_p[7:3], {3{|i_p[2:0]}}};
endmodule

module hslp_pp_slot
  import hslp_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic [1:0] i_mode,
  output logic [7:0] o_pp
);

  logic [7:0] w_exact;
  logic [7:0] w_ap1;
  logic [7:0] w_ap3;

  assign w_exact = {4'b0, i_x} * {4'b0, i_y};

  hslp_ap1 u_ap1 (.i_p(w_exact), .o_p(w_ap1));
  hslp_ap3 u_ap3 (.i_p(w_exact), .o_p(w_ap3));

  always_comb begin
    o_pp = w_exact;
    case (i_mode)
      PP_AP1:  o_pp = w_ap1;
      PP_AP3:  o_pp = w_ap3;
      default: o_pp = w_exact;
    endcase
  end

endmodule

// File: rtl/hslp_seq_mul.sv
// 8x8 unsigned multiplier built from four 4x4 partial products, one per cycle,
// accumulated at 17 bits so approximate sums above 16 bits show up on ovf.
//
// state | meaning
// IDLE  | waiting for an operand pair (ready only once out of reset)
// HH    | add ah*bh << 8
// HL    | add ah*bl << 4
// LH    | add al*bh << 4
// LL    | add al*bl
// DONE  | result presented until out_ready
module hslp_seq_mul
  import hslp_pkg::*;
#(
  parameter int EARLY_ZERO = 1,
  parameter int LL_APPROX  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        ovf
);

  state_t             r_state;
  logic               r_run;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic               r_approx;
  logic [ACC_W-1:0]   r_acc;

  logic [3:0]         w_x;
  logic [3:0]         w_y;
  logic [1:0]         w_mode;
  logic [7:0]         w_pp;
  logic [ACC_W-1:0]   w_addend;
  logic               w_zero;

  always_comb begin
    w_x      = r_a[3:0];
    w_y      = r_b[3:0];
    w_addend = '0;
    case (r_state)
      ST_HH: begin w_x = r_a[7:4]; w_y = r_b[7:4]; w_addend = ACC_W'(w_pp) << SH_HH; end
      ST_HL: begin w_x = r_a[7:4]; w_y = r_b[3:0]; w_addend = ACC_W'(w_pp) << SH_HL; end
      ST_LH: begin w_x = r_a[3:0]; w_y = r_b[7:4]; w_addend = ACC_W'(w_pp) << SH_LH; end
      ST_LL: begin w_x = r_a[3:0]; w_y = r_b[3:0]; w_addend = ACC_W'(w_pp) << SH_LL; end
      default: ;
    endcase
  end

  always_comb begin
    w_mode = PP_EXACT;
    if (r_approx)
      w_mode = (r_state == ST_LL && LL_APPROX != 0) ? PP_AP3 : PP_AP1;
  end

  hslp_pp_slot u_slot (.i_x(w_x), .i_y(w_y), .i_mode(w_mode), .o_pp(w_pp));

  assign w_zero = (EARLY_ZERO != 0) && ((a == 8'd0) || (b == 8'd0));

  // r_run keeps in_ready low while held in reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_run    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_approx <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_IDLE: if (r_run && in_valid) begin
          r_a      <= a;
          r_b      <= b;
          r_approx <= approx_en;
          r_acc    <= '0;
          r_state  <= w_zero ? ST_DONE : ST_HH;
        end
        ST_HH: begin r_acc <= r_acc + w_addend; r_state <= ST_HL;   end
        ST_HL: begin r_acc <= r_acc + w_addend; r_state <= ST_LH;   end
        ST_LH: begin r_acc <= r_acc + w_addend; r_state <= ST_LL;   end
        ST_LL: begin r_acc <= r_acc + w_addend; r_state <= ST_DONE; end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_run && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign prod      = r_acc[15:0];
  assign ovf       = r_acc[16];

endmodule

// File: tb/tb_hslp_seq_mul.sv
// Directed and sampled-sweep bench for hslp_seq_mul; u0 default params,
// u1 with LL_APPROX=0 (shares u0 handshakes), u2 with EARLY_ZERO=0.
module tb_hslp_seq_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid2;
  logic        out_ready, out_ready2;
  logic [7:0]  a, b;
  logic        approx_en;

  logic        in_ready, out_valid, ovf;
  logic [15:0] prod;
  logic        in_ready1, out_valid1, ovf1;
  logic [15:0] prod1;
  logic        in_ready2, out_valid2, ovf2;
  logic [15:0] prod2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hslp_seq_mul #(.EARLY_ZERO(1), .LL_APPROX(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod), .ovf(ovf));

  hslp_seq_mul #(.EARLY_ZERO(1), .LL_APPROX(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid1),
    .out_ready(out_ready), .prod(prod1), .ovf(ovf1));

  hslp_seq_mul #(.EARLY_ZERO(0), .LL_APPROX(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid2),
    .out_ready(out_ready2), .prod(prod2), .ovf(ovf2));

  // Reference approximations written from their definition: any set bit in the
  // low 2 (ap1) or 3 (ap3) bits forces all of those bits high.
  function automatic int ref_pp(input int x, input int y, input bit apx, input bit wide);
    int p;
    int m;
    p = x * y;
    m = wide ? 7 : 3;
    if (apx && (p % (m + 1)) != 0) p = p | m;
    return p;
  endfunction

  function automatic int ref_mul(input int av, input int bv, input bit apx, input bit ll_ap3);
    int ah, al, bh, bl;
    ah = av / 16; al = av % 16; bh = bv / 16; bl = bv % 16;
    return ref_pp(ah, bh, apx, 0) * 256 + ref_pp(ah, bl, apx, 0) * 16 +
           ref_pp(al, bh, apx, 0) * 16 + ref_pp(al, bl, apx, ll_ap3);
  endfunction

  // Issue one pair on u0/u1, scramble the inputs after capture, wait for the result
  // and complete the handshake (out_ready assumed 1).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tax,
                        output int lat, output logic [16:0] r0, output logic [16:0] r1);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: in_ready=%0b required 1", in_ready);
    end
    a = ta; b = tb; approx_en = tax; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb; approx_en = ~tax;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r0 = {ovf, prod};
    r1 = {ovf1, prod1};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1; a = 8'h5A; b = 8'hA5; approx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, ovf, prod} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%0b ov=%0b ovf=%0b prod=%h required all 0",
               in_ready, out_valid, ovf, prod);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_before_edge: got %0b required 0", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ready_after_reset: rdy=%0b ov=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_exact();
    logic [7:0]  va [6] = '{8'hFF, 8'h12, 8'h03, 8'hFF, 8'h10, 8'hA5};
    logic [7:0]  vb [6] = '{8'hFF, 8'h34, 8'h05, 8'h01, 8'h10, 8'h5A};
    logic [16:0] ve [6] = '{17'h0FE01, 17'h003A8, 17'h0000F, 17'h000FF, 17'h00100, 17'h03A02};
    int lat;
    logic [16:0] r0, r1;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 1'b0, lat, r0, r1);
      n_cmp++;
      if (lat != 5 || r0 !== ve[i] || r1 !== ve[i]) begin
        n_bad++;
        $display("FAIL exact_%0d: lat=%0d u0=%h u1=%h required lat=5 result=%h",
                 i, lat, r0, r1, ve[i]);
      end
    end
  endtask

  task automatic test_early_zero();
    int lat;
    logic [16:0] r0, r1;
    run_op(8'h00, 8'h5A, 1'b0, lat, r0, r1);
    n_cmp++;
    if (lat != 1 || r0 !== 17'd0) begin
      n_bad++; $display("FAIL early_zero_a: lat=%0d result=%h required lat=1 result=0", lat, r0);
    end
    run_op(8'hC3, 8'h00, 1'b1, lat, r0, r1);
    n_cmp++;
    if (lat != 1 || r0 !== 17'd0) begin
      n_bad++; $display("FAIL early_zero_b: lat=%0d result=%h required lat=1 result=0", lat, r0);
    end
    a = 8'h00; b = 8'h5A; approx_en = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat != 5 || {ovf2, prod2} !== 17'd0) begin
      n_bad++;
      $display("FAIL no_early_zero: lat=%0d result=%h required lat=5 result=0", lat, {ovf2, prod2});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int lat;
    bit bad;
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; approx_en = 1'b1;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (prod !== 16'h03A8 || ovf !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (lat != 5 || bad) begin
      n_bad++;
      $display("FAIL hold_stable: lat=%0d prod=%h rdy=%0b ov=%0b required 5/03a8/0/1",
               lat, prod, in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: rdy=%0b ov=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    logic [16:0] r0, r1;
    a = 8'hAB; b = 8'hCD; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, ovf, prod} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy=%0b ov=%0b ovf=%0b prod=%h required all 0",
               in_ready, out_valid, ovf, prod);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL reset_abort: out_valid seen=1 required 0");
    end
    run_op(8'h03, 8'h05, 1'b0, lat, r0, r1);
    n_cmp++;
    if (lat != 5 || r0 !== 17'h0000F) begin
      n_bad++; $display("FAIL after_reset_op: lat=%0d result=%h required 5/0000f", lat, r0);
    end
  endtask

  task automatic test_approx_directed();
    int lat;
    logic [16:0] r0, r1;
    // 15*15=225 -> ap1 227, ap3 231: 227*256 + 2*227*16 + 231 = 0x10047 (ap1 at LL: 0x10043)
    run_op(8'hFF, 8'hFF, 1'b1, lat, r0, r1);
    n_cmp++;
    if (lat != 5 || r0 !== 17'h10047 || r1 !== 17'h10043) begin
      n_bad++;
      $display("FAIL approx_ff: lat=%0d u0=%h u1=%h required 5/10047/10043", lat, r0, r1);
    end
    // 1*1=1 -> ap1 3, ap3 7: 768 + 96 + 7 = 0x367 (ap1 at LL: 0x363)
    run_op(8'h11, 8'h11, 1'b1, lat, r0, r1);
    n_cmp++;
    if (r0 !== 17'h00367 || r1 !== 17'h00363) begin
      n_bad++; $display("FAIL approx_11: u0=%h u1=%h required 00367/00363", r0, r1);
    end
  endtask

  task automatic test_approx_sweep();
    int lat;
    int av, bv, e0, e1;
    logic [16:0] r0, r1;
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 24; j++) begin
        av = (i * 37 + 5) % 256;
        bv = (j * 53 + 11) % 256;
        if (i == 23) av = 255;
        e0 = ref_mul(av, bv, 1, 1);
        e1 = ref_mul(av, bv, 1, 0);
        run_op(av[7:0], bv[7:0], 1'b1, lat, r0, r1);
        n_cmp++;
        if (int'(r0) != e0 || int'(r1) != e1) begin
          n_bad++;
          $display("FAIL sweep a=%h b=%h: u0=%h u1=%h required %h/%h",
                   av[7:0], bv[7:0], r0, r1, e0[16:0], e1[16:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa [4] = '{8'h12, 8'hFF, 8'h03, 8'h80};
    logic [7:0]  pb [4] = '{8'h34, 8'hFF, 8'h05, 8'h80};
    logic [15:0] pe [4] = '{16'h03A8, 16'hFE01, 16'h000F, 16'h4000};
    int acc_t [4];
    logic [15:0] res [4];
    int k, nr, cyc;
    bit rdy;
    k = 0; nr = 0; cyc = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    cyc = 0;
    a = pa[0]; b = pb[0]; approx_en = 1'b0; in_valid = 1'b1;
    rdy = in_ready;
    while (nr < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy && k < 4) begin
        acc_t[k] = cyc;
        k++;
        if (k < 4) begin a = pa[k]; b = pb[k]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        res[nr] = prod;
        nr++;
      end
      rdy = in_ready;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (nr != 4 || k != 4) begin
      n_bad++; $display("FAIL b2b_count: results=%0d accepts=%0d required 4/4", nr, k);
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (acc_t[i] - acc_t[i-1] != 6) begin
          n_bad++; $display("FAIL b2b_spacing_%0d: got %0d required 6", i, acc_t[i] - acc_t[i-1]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (res[i] !== pe[i]) begin
          n_bad++; $display("FAIL b2b_result_%0d: got %h required %h", i, res[i], pe[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_early_zero();
    test_hold();
    test_reset_mid();
    test_approx_directed();
    test_approx_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
